cardinal_nic_q: RTL and testbench

Parametrised network interface for the cardinal CMP ring: the next generation of the per-node NIC between a cardinal processor and its gold-ring router port. Replaces the single-entry channel buffers with DEPTH-deep input and output FIFOs, generalises data width, and reports occupancy in the status words. Four instances sit in the NIC layer of the CMP top. Processor side: 2-bit register address. Ring side: send/ready/data handshakes plus the router's polarity.

---
 rtl/cardinal_nic_pkg.sv | 30 +++
 rtl/cardinal_nic_fifo.sv | 71 +++++++
 rtl/cardinal_nic_q.sv | 134 +++++++++++++
 tb/tb_cardinal_nic_q.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_pkg
// Description : Shared constants for the cardinal ring NIC: processor-side
//               register map, status-word field positions and the packet
//               virtual-channel bit.
// Revision    : 1.0 - initial release
// ============================================================================
package cardinal_nic_pkg;

    // Processor-side register map
    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Virtual-channel bit of a packet (big-endian index)
    localparam int c_VC_BIT = 0;

    // Status word layout, as offsets back from the last bit (DATA_W-1).
    // Flag sits at DATA_W-1; occupancy field spans DATA_W-9 .. DATA_W-2.
    localparam int c_STAT_FLAG_OFS   = 1;
    localparam int c_STAT_CNT_LO_OFS = 2;
    localparam int c_STAT_CNT_W      = 8;

    // Optional dropped-write counter occupies bits [0:c_DROP_CNT_W-1]
    localparam int c_DROP_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/cardinal_nic_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_fifo
// Description : DEPTH-entry synchronous FIFO with combinational head (zero
//               when empty) and registered occupancy count. Full/empty come
//               from the registered count only, so a pop on a full FIFO
//               frees space from the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_nic_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [0:DATA_W-1]       i_data,
    input  logic                    i_pop,
    output logic [0:DATA_W-1]       o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [0:DATA_W-1] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; entries are never cleared, reset only rewinds pointers
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cardinal_nic_q.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_q
// Description : Cardinal CMP ring NIC with DEPTH-deep input (router->CPU)
//               and output (CPU->router) FIFOs. Processor accesses a 2-bit
//               register map; ring side uses send/ready handshakes and only
//               sends a head packet whose VC bit matches net_polarity.
//               Optional feature macro: CARDINAL_NIC_DROP_CNT_EN adds a
//               16-bit saturating dropped-write counter in output status.
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_nic_q #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di
);

    import cardinal_nic_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int c_FLAG_IDX = DATA_W - c_STAT_FLAG_OFS;
    localparam int c_CNT_HI   = DATA_W - c_STAT_CNT_LO_OFS;
    localparam int c_CNT_LO   = c_CNT_HI - c_STAT_CNT_W + 1;

    logic [0:DATA_W-1] r_d_out;
    logic [0:DATA_W-1] w_in_head;
    logic [0:DATA_W-1] w_out_head;
    logic [CNT_W-1:0]  w_in_count;
    logic [CNT_W-1:0]  w_out_count;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_out_full;
    logic              w_out_empty;
    logic              w_rd;
    logic              w_wr_out;
    logic              w_in_pop;
    logic [0:DATA_W-1] w_in_stat;
    logic [0:DATA_W-1] w_out_stat;

    assign w_rd     = nicEn && !nicWrEn;
    assign w_wr_out = nicEn && nicWrEn && (addr == NIC_OUT_DATA);
    assign w_in_pop = w_rd && (addr == NIC_IN_DATA);

    assign net_ri = !w_in_full;
    assign net_so = !w_out_empty && (w_out_head[c_VC_BIT] == net_polarity);
    assign net_do = w_out_head;
    assign d_out  = r_d_out;

    cardinal_nic_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (net_si),
        .i_data  (net_di),
        .i_pop   (w_in_pop),
        .o_head  (w_in_head),
        .o_count (w_in_count),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    cardinal_nic_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_out),
        .i_data  (d_in),
        .i_pop   (net_ro && net_so),
        .o_head  (w_out_head),
        .o_count (w_out_count),
        .o_full  (w_out_full),
        .o_empty (w_out_empty)
    );

`ifdef CARDINAL_NIC_DROP_CNT_EN
    logic [c_DROP_CNT_W-1:0] r_drop_cnt;

    // Count processor writes lost to a full output FIFO, saturating
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_wr_out && w_out_full && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + c_DROP_CNT_W'(1);
        end
    end
`endif

    // Assemble the two status words from registered FIFO state
    always_comb begin
        w_in_stat  = '0;
        w_out_stat = '0;
        w_in_stat[c_FLAG_IDX]           = !w_in_empty;
        w_in_stat[c_CNT_LO:c_CNT_HI]    = c_STAT_CNT_W'(w_in_count);
        w_out_stat[c_FLAG_IDX]          = w_out_full;
        w_out_stat[c_CNT_LO:c_CNT_HI]   = c_STAT_CNT_W'(w_out_count);
`ifdef CARDINAL_NIC_DROP_CNT_EN
        w_out_stat[0:c_DROP_CNT_W-1]    = r_drop_cnt;
`endif
    end

    // Registered processor read data; holds between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            case (addr)
                NIC_IN_DATA:  r_d_out <= w_in_head;
                NIC_IN_STAT:  r_d_out <= w_in_stat;
                NIC_OUT_STAT: r_d_out <= w_out_stat;
                default:      r_d_out <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_cardinal_nic_q
// Description : Self-checking bench for cardinal_nic_q (DATA_W=64, DEPTH=4).
//               Table of processor/output-path vectors, hand sequences for
//               polarity, full-FIFO and reset corners, and a queue model of
//               the input FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic_q;

    localparam int c_DEPTH = 4;
`ifdef CARDINAL_NIC_DROP_CNT_EN
    localparam logic [63:0] c_DROP1 = 64'h0001_0000_0000_0000;
`else
    localparam logic [63:0] c_DROP1 = 64'h0;
`endif

    logic        clk;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    int checks   = 0;
    int failures = 0;
    logic [63:0] in_q[$];

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  a;
        logic [63:0] din;
        logic        ro;
        logic [63:0] exp_dout;
        logic        exp_so;
        logic [63:0] exp_do;
    } vec_t;

    vec_t vecs[18];

    cardinal_nic_q #(
        .DATA_W (64),
        .DEPTH  (c_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] a,
                                input logic [63:0] din, input logic ro,
                                input logic [63:0] exp_dout, input logic exp_so,
                                input logic [63:0] exp_do);
        vec_t v;
        v.en = en; v.wr = wr; v.a = a; v.din = din; v.ro = ro;
        v.exp_dout = exp_dout; v.exp_so = exp_so; v.exp_do = exp_do;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [63:0] exp, input string nm);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
        chk(nm, d_out, exp);
    endtask

    task automatic wr_out(input logic [63:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = v;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    // One cycle on the input path, scored against the queue model
    task automatic in_cycle(input logic si, input logic [63:0] di, input logic rd,
                            input string nm);
        logic [63:0] exp_rd;
        logic        had;
        logic        will_push;
        net_si = si; net_di = di; nicEn = rd; nicWrEn = 1'b0; addr = 2'b00;
        had       = (in_q.size() != 0);
        exp_rd    = had ? in_q[0] : 64'h0;
        will_push = si && (in_q.size() < c_DEPTH);
        tick();
        if (had && rd) void'(in_q.pop_front());
        if (will_push) in_q.push_back(di);
        if (rd) chk({nm, " d_out"}, d_out, exp_rd);
        chk({nm, " net_ri"}, net_ri, in_q.size() < c_DEPTH);
        net_si = 1'b0; nicEn = 1'b0;
    endtask

    function automatic logic [63:0] in_stat_exp();
        return (64'(in_q.size()) << 1) | 64'(in_q.size() != 0);
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 2'b01, 64'h0,  0, 64'h0,             0, 64'h0);
        vecs[1]  = mk(1, 0, 2'b11, 64'h0,  0, 64'h0,             0, 64'h0);
        vecs[2]  = mk(1, 1, 2'b10, 64'h11, 0, 64'h0,             1, 64'h11);
        vecs[3]  = mk(1, 1, 2'b10, 64'h22, 0, 64'h0,             1, 64'h11);
        vecs[4]  = mk(1, 1, 2'b10, 64'h33, 0, 64'h0,             1, 64'h11);
        vecs[5]  = mk(1, 1, 2'b10, 64'h44, 0, 64'h0,             1, 64'h11);
        vecs[6]  = mk(1, 1, 2'b10, 64'h55, 0, 64'h0,             1, 64'h11);
        vecs[7]  = mk(1, 0, 2'b11, 64'h0,  0, 64'h9 | c_DROP1,   1, 64'h11);
        vecs[8]  = mk(0, 0, 2'b11, 64'h0,  0, 64'h9 | c_DROP1,   1, 64'h11);
        vecs[9]  = mk(1, 0, 2'b10, 64'h0,  0, 64'h0,             1, 64'h11);
        vecs[10] = mk(0, 0, 2'b00, 64'h0,  1, 64'h0,             1, 64'h22);
        vecs[11] = mk(0, 0, 2'b00, 64'h0,  1, 64'h0,             1, 64'h33);
        vecs[12] = mk(1, 0, 2'b11, 64'h0,  0, 64'h4 | c_DROP1,   1, 64'h33);
        vecs[13] = mk(0, 0, 2'b00, 64'h0,  1, 64'h4 | c_DROP1,   1, 64'h44);
        vecs[14] = mk(0, 0, 2'b00, 64'h0,  1, 64'h4 | c_DROP1,   0, 64'h0);
        vecs[15] = mk(1, 0, 2'b11, 64'h0,  0, c_DROP1,           0, 64'h0);
        vecs[16] = mk(1, 1, 2'b00, 64'hDEAD, 0, c_DROP1,         0, 64'h0);
        vecs[17] = mk(1, 0, 2'b01, 64'h0,  0, 64'h0,             0, 64'h0);

        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst d_out", d_out, 64'h0);
        chk("rst net_so", net_so, 1'b0);
        chk("rst net_ri", net_ri, 1'b1);
        chk("rst net_do", net_do, 64'h0);

        // Output path and register map vectors
        for (int i = 0; i < 18; i++) begin
            nicEn = vecs[i].en; nicWrEn = vecs[i].wr; addr = vecs[i].a;
            d_in = vecs[i].din; net_ro = vecs[i].ro; net_polarity = 1'b0;
            tick();
            chk($sformatf("vec%0d d_out", i), d_out, vecs[i].exp_dout);
            chk($sformatf("vec%0d net_so", i), net_so, vecs[i].exp_so);
            chk($sformatf("vec%0d net_do", i), net_do, vecs[i].exp_do);
            chk($sformatf("vec%0d net_ri", i), net_ri, 1'b1);
        end
        nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;

        // Polarity gating and no reordering past a stalled head
        wr_out(64'h8000_0000_0000_00A5);
        chk("pol vc1 so", net_so, 1'b0);
        chk("pol vc1 do", net_do, 64'h8000_0000_0000_00A5);
        wr_out(64'h0000_0000_0000_00B6);
        net_ro = 1'b1;
        tick();
        chk("pol stall so", net_so, 1'b0);
        chk("pol stall do", net_do, 64'h8000_0000_0000_00A5);
        net_polarity = 1'b1;
        #1;
        chk("pol match so", net_so, 1'b1);
        tick();
        chk("pol pop do", net_do, 64'h0000_0000_0000_00B6);
        chk("pol vc0 so", net_so, 1'b0);
        net_polarity = 1'b0;
        #1;
        chk("pol vc0 match so", net_so, 1'b1);
        tick();
        chk("pol drain do", net_do, 64'h0);
        chk("pol drain so", net_so, 1'b0);
        net_ro = 1'b0;

        // Router fills input FIFO; extra send while full is ignored
        for (int i = 0; i < 4; i++) in_cycle(1'b1, 64'hA0 + 64'(i), 1'b0, "rt push");
        in_cycle(1'b1, 64'hA4, 1'b0, "rt full");
        rd_reg(2'b01, in_stat_exp(), "in stat full");
        for (int i = 0; i < 5; i++) in_cycle(1'b0, 64'h0, 1'b1, "rd in");
        rd_reg(2'b01, in_stat_exp(), "in stat empty");

        // Full input FIFO: send plus pop in the same cycle, then retry
        for (int i = 0; i < 4; i++) in_cycle(1'b1, 64'hB0 + 64'(i), 1'b0, "fill");
        in_cycle(1'b1, 64'hB4, 1'b1, "full pop");
        in_cycle(1'b1, 64'hB4, 1'b0, "retry");
        rd_reg(2'b01, in_stat_exp(), "stat refull");
        in_cycle(1'b0, 64'h0, 1'b1, "drain1");
        in_cycle(1'b1, 64'hB5, 1'b1, "push pop");
        rd_reg(2'b01, in_stat_exp(), "stat push pop");
        for (int i = 0; i < 3; i++) in_cycle(1'b0, 64'h0, 1'b1, "drain");
        in_cycle(1'b1, 64'hB6, 1'b1, "empty push pop");
        in_cycle(1'b0, 64'h0, 1'b1, "late read");

        // Reset with two entries in each FIFO and a transfer in flight
        in_cycle(1'b1, 64'hC0, 1'b0, "pre rst");
        in_cycle(1'b1, 64'hC1, 1'b0, "pre rst");
        wr_out(64'hD0);
        wr_out(64'hD1);
        rd_reg(2'b01, in_stat_exp(), "pre rst stat");
        reset = 1'b0; net_si = 1'b1; net_di = 64'hC2; net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'hD2;
        tick();
        reset = 1'b1; net_si = 1'b0; net_ro = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0;
        in_q.delete();
        chk("mid rst d_out", d_out, 64'h0);
        chk("mid rst net_so", net_so, 1'b0);
        chk("mid rst net_ri", net_ri, 1'b1);
        chk("mid rst net_do", net_do, 64'h0);
        rd_reg(2'b01, 64'h0, "post rst in stat");
        rd_reg(2'b11, 64'h0, "post rst out stat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
